// File: rtl/quarter_seq_ctrl.sv
// rtl/quarter_seq_ctrl.sv - issue/accumulate sequencer for one 4x4 fusible quarter unit
// Optional QUARTER_SEQ_SAT_EN: saturating accumulate instead of wrap-around.
module quarter_seq_ctrl #(
    parameter int ACC_W  = 24,
    parameter int QU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_signed,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             err,
    output logic [3:0]       qu_a,
    output logic [3:0]       qu_b,
    output logic [1:0]       qu_sa,
    output logic [1:0]       qu_sb,
    output logic             qu_sft_ctrl_1,
    output logic             qu_sft_ctrl_2,
    output logic [1:0]       qu_sft_ctrl_3,
    input  logic [15:0]      qu_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;
    localparam logic [1:0] M_4B    = 2'b00;
    localparam logic [1:0] M_8B    = 2'b01;
    localparam logic [1:0] M_2B    = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;
    // Headroom for a 17-bit signed product shifted by 8 plus the accumulator.
    localparam int EXT_W = ACC_W + 10;

    logic [1:0]       state;
    logic [7:0]       a_r, b_r;
    logic [1:0]       mode_r;
    logic             signed_r, last_r;
    logic [1:0]       pass;
    logic [ACC_W-1:0] acc;

    logic [QU_LAT-1:0] dl_valid, dl_pk, dl_ext;
    logic [3:0]        dl_shift [QU_LAT];

    logic       issuing, a_hi, b_hi, last_pass, iss_pk, iss_ext;
    logic [3:0] iss_shift;

    assign issuing   = (state == S_ISSUE);
    assign a_hi      = (mode_r == M_8B) && pass[0];
    assign b_hi      = (mode_r == M_8B) && pass[1];
    assign last_pass = (mode_r != M_8B) || (pass == 2'd3);
    assign iss_pk    = (mode_r == M_2B);
    assign iss_shift = {a_hi & b_hi, a_hi ^ b_hi, 2'b00};
    assign iss_ext   = (|qu_sa) | (|qu_sb);

    always_comb begin
        qu_a          = 4'd0;
        qu_b          = 4'd0;
        qu_sa         = 2'b00;
        qu_sb         = 2'b00;
        qu_sft_ctrl_1 = 1'b0;
        qu_sft_ctrl_2 = 1'b0;
        qu_sft_ctrl_3 = 2'b00;
        if (issuing) begin
            qu_a = a_hi ? a_r[7:4] : a_r[3:0];
            qu_b = b_hi ? b_r[7:4] : b_r[3:0];
            if (iss_pk) begin
                qu_sa = {2{signed_r}};
                qu_sb = {2{signed_r}};
            end else begin
                // Only the slice carrying the operand MSB is signed.
                qu_sa = {signed_r & ((mode_r == M_4B) | a_hi), 1'b0};
                qu_sb = {signed_r & ((mode_r == M_4B) | b_hi), 1'b0};
                {qu_sft_ctrl_3, qu_sft_ctrl_2, qu_sft_ctrl_1} = 4'b1011;
            end
        end
    end

    logic                    tail_valid, tail_pk, tail_ext;
    logic [3:0]              tail_shift;
    logic signed [EXT_W-1:0] cap, addend, sum;
    logic [ACC_W-1:0]        acc_next;

    assign tail_valid = dl_valid[QU_LAT-1];
    assign tail_pk    = dl_pk[QU_LAT-1];
    assign tail_ext   = dl_ext[QU_LAT-1];
    assign tail_shift = dl_shift[QU_LAT-1];

    always_comb begin
        cap = '0;
        if (tail_pk) begin
            for (int i = 0; i < 4; i++)
                cap = cap + {{(EXT_W-4){tail_ext & qu_out[4*i+3]}}, qu_out[4*i +: 4]};
        end else begin
            cap = {{(EXT_W-16){tail_ext & qu_out[15]}}, qu_out};
        end
        addend = cap <<< tail_shift;
        sum    = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc} + addend;
    end

`ifdef QUARTER_SEQ_SAT_EN
    logic ovf;
    assign ovf      = !((&sum[EXT_W-1:ACC_W-1]) || !(|sum[EXT_W-1:ACC_W-1]));
    assign acc_next = ovf ? {sum[EXT_W-1], {(ACC_W-1){~sum[EXT_W-1]}}} : sum[ACC_W-1:0];
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[EXT_W-1:ACC_W];
    assign acc_next      = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_pk    <= '0;
            dl_ext   <= '0;
            for (int i = 0; i < QU_LAT; i++) dl_shift[i] <= 4'd0;
        end else begin
            dl_valid[0] <= issuing;
            dl_pk[0]    <= iss_pk;
            dl_ext[0]   <= iss_ext;
            dl_shift[0] <= iss_shift;
            for (int i = 1; i < QU_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_pk[i]    <= dl_pk[i-1];
                dl_ext[i]   <= dl_ext[i-1];
                dl_shift[i] <= dl_shift[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_r      <= 8'd0;
            b_r      <= 8'd0;
            mode_r   <= 2'b00;
            signed_r <= 1'b0;
            last_r   <= 1'b0;
            pass     <= 2'd0;
            acc      <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == S_HOLD && out_ready) acc <= '0;
            else if (tail_valid)              acc <= acc_next;
            case (state)
                S_IDLE: if (in_valid) begin
                    a_r      <= in_a;
                    b_r      <= in_b;
                    mode_r   <= in_mode;
                    signed_r <= in_signed;
                    last_r   <= in_last;
                    pass     <= 2'd0;
                    if (in_mode == M_RSVD) begin
                        err   <= 1'b1;
                        state <= S_DRAIN;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pass <= pass + 2'd1;
                    if (last_pass) state <= S_DRAIN;
                end
                S_DRAIN: if (!(|dl_valid)) state <= last_r ? S_HOLD : S_IDLE;
                default: if (out_ready) state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_HOLD);
    assign out_data  = out_valid ? acc : '0;

endmodule

// File: tb/tb_quarter_seq_ctrl.sv
// tb/tb_quarter_seq_ctrl.sv - directed vector bench for quarter_seq_ctrl with a behavioural quarter unit
module tb_quarter_seq_ctrl;
    localparam int ACC_W  = 16;
    localparam int QU_LAT = 1;
`ifdef QUARTER_SEQ_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP = 16'hFE01;
`endif

    logic             clk, rst_n;
    logic             in_valid, in_ready, in_signed, in_last;
    logic [7:0]       in_a, in_b;
    logic [1:0]       in_mode;
    logic             out_valid, out_ready, err;
    logic [ACC_W-1:0] out_data;
    logic [3:0]       qu_a, qu_b;
    logic [1:0]       qu_sa, qu_sb, qu_sft_ctrl_3;
    logic             qu_sft_ctrl_1, qu_sft_ctrl_2;
    logic [15:0]      qu_out;
    logic [3:0]       qu_cfg;

    quarter_seq_ctrl #(.ACC_W(ACC_W), .QU_LAT(QU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
        .qu_a(qu_a), .qu_b(qu_b), .qu_sa(qu_sa), .qu_sb(qu_sb),
        .qu_sft_ctrl_1(qu_sft_ctrl_1), .qu_sft_ctrl_2(qu_sft_ctrl_2),
        .qu_sft_ctrl_3(qu_sft_ctrl_3), .qu_out(qu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign qu_cfg = {qu_sft_ctrl_3, qu_sft_ctrl_2, qu_sft_ctrl_1};

    // Quarter unit: fused 4x4 multiply for config 1011, four 2x2 cross products otherwise.
    function automatic logic [15:0] qu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] sa, input logic [1:0] sb,
                                             input logic [3:0] cfg);
        int av, bv, p;
        logic [15:0] r;
        r = '0;
        if (cfg == 4'b1011) begin
            av = int'(a); if (sa[1] && a[3]) av -= 16;
            bv = int'(b); if (sb[1] && b[3]) bv -= 16;
            p = av * bv;
            r = p[15:0];
        end else begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    av = int'(a[2*i +: 2]); if (sa[i] && a[2*i+1]) av -= 4;
                    bv = int'(b[2*j +: 2]); if (sb[j] && b[2*j+1]) bv -= 4;
                    p = av * bv;
                    r[4*(2*i+j) +: 4] = p[3:0];
                end
        end
        return r;
    endfunction

    logic [15:0] qu_pipe [QU_LAT];
    always @(posedge clk) begin
        qu_pipe[0] <= qu_model(qu_a, qu_b, qu_sa, qu_sb, qu_cfg);
        for (int i = 1; i < QU_LAT; i++) qu_pipe[i] <= qu_pipe[i-1];
    end
    assign qu_out = qu_pipe[QU_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        sgn;
        logic        last;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  qa;
        logic [3:0]  qb;
        logic [3:0]  cfg;
        logic [1:0]  sa;
        logic [1:0]  sb;
        int          lat;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [1:0] mode, input logic sgn,
                                input logic last, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] qa, input logic [3:0] qb, input logic [3:0] cfg,
                                input logic [1:0] sa, input logic [1:0] sb, input int lat,
                                input int hold, input logic [15:0] exp);
        vec_t v;
        v.name = name; v.mode = mode; v.sgn = sgn; v.last = last; v.a = a; v.b = b;
        v.qa = qa; v.qb = qb; v.cfg = cfg; v.sa = sa; v.sb = sb;
        v.lat = lat; v.hold = hold; v.exp = exp;
        return v;
    endfunction

    task automatic start_op(input string tag, input logic [1:0] mode, input logic sgn,
                            input logic last, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk(tag, "in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_mode = mode; in_signed = sgn; in_last = last; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int  e;
        logic got;
        start_op(v.name, v.mode, v.sgn, v.last, v.a, v.b);
        e = 0;
        chk(v.name, "qu_a", qu_a, v.qa);
        chk(v.name, "qu_b", qu_b, v.qb);
        chk(v.name, "cfg", qu_cfg, v.cfg);
        chk(v.name, "qu_sa", qu_sa, v.sa);
        chk(v.name, "qu_sb", qu_sb, v.sb);
        chk(v.name, "err", err, v.mode == 2'b11);
        got = 1'b0;
        while (!got && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
            if (e == 1) chk(v.name, "err_pulse_end", err, 0);
            if (v.last ? out_valid : in_ready) got = 1'b1;
        end
        chk(v.name, "done", got, 1);
        if (got && v.last) begin
            if (v.lat != 0) chk(v.name, "latency", e, v.lat);
            chk(v.name, "out_data", out_data, v.exp);
            chk(v.name, "in_ready_hold", in_ready, 0);
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                chk(v.name, "bp_valid", out_valid, 1);
                chk(v.name, "bp_data", out_data, v.exp);
                chk(v.name, "bp_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk(v.name, "released_valid", out_valid, 0);
            chk(v.name, "released_ready", in_ready, 1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, "in_ready", in_ready, 1);
        chk(tag, "out_valid", out_valid, 0);
        chk(tag, "out_data", out_data, 0);
        chk(tag, "err", err, 0);
        chk(tag, "qu_ab", {qu_a, qu_b}, 0);
        chk(tag, "qu_s", {qu_sa, qu_sb}, 0);
        chk(tag, "cfg", qu_cfg, 0);
    endtask

    vec_t vecs [10];
    logic [3:0] po_a [4];
    logic [3:0] po_b [4];
    logic [1:0] po_sa [4];
    logic [1:0] po_sb [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic got;

        vecs[0] = mk("m00_signed", 2'b00, 1, 1, 8'h0D, 8'h05, 4'hD, 4'h5, 4'hB, 2'b10, 2'b10, 3, 5, 16'hFFF1);
        vecs[1] = mk("m01_unsigned", 2'b01, 0, 1, 8'd200, 8'd100, 4'h8, 4'h4, 4'hB, 2'b00, 2'b00, 6, 0, 16'd20000);
        vecs[2] = mk("m01_signed", 2'b01, 1, 1, 8'h80, 8'h80, 4'h0, 4'h0, 4'hB, 2'b00, 2'b00, 6, 0, 16'd16384);
        vecs[3] = mk("acc_3x4", 2'b00, 1, 0, 8'h03, 8'h04, 4'h3, 4'h4, 4'hB, 2'b10, 2'b10, 0, 0, 16'h0);
        vecs[4] = mk("acc_m2x7", 2'b00, 1, 1, 8'h0E, 8'h07, 4'hE, 4'h7, 4'hB, 2'b10, 2'b10, 3, 0, 16'hFFFE);
        vecs[5] = mk("m10_unsigned", 2'b10, 0, 1, 8'h0F, 8'h05, 4'hF, 4'h5, 4'h0, 2'b00, 2'b00, 3, 0, 16'd12);
        vecs[6] = mk("m10_signed", 2'b10, 1, 1, 8'h0F, 8'h05, 4'hF, 4'h5, 4'h0, 2'b11, 2'b11, 3, 0, 16'hFFFC);
        vecs[7] = mk("m01_255sq", 2'b01, 0, 1, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hB, 2'b00, 2'b00, 6, 0, SAT_EXP);
        vecs[8] = mk("acc_u3x4", 2'b00, 0, 0, 8'h03, 8'h04, 4'h3, 4'h4, 4'hB, 2'b00, 2'b00, 0, 0, 16'h0);
        vecs[9] = mk("m11_rsvd", 2'b11, 0, 1, 8'h5A, 8'hA5, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 0, 0, 16'd12);

        po_a  = '{4'h8, 4'hC, 4'h8, 4'hC};
        po_b  = '{4'h4, 4'h4, 4'h6, 4'h6};
        po_sa = '{2'b00, 2'b10, 2'b00, 2'b10};
        po_sb = '{2'b00, 2'b00, 2'b10, 2'b10};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
        in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Pass ordering and slice signs for signed 8-bit: -56 * 100.
        start_op("pass_order", 2'b01, 1, 1, 8'hC8, 8'h64);
        e = 0;
        for (int p = 0; p < 4; p++) begin
            chk("pass_order", $sformatf("p%0d_ab", p), {qu_a, qu_b}, {po_a[p], po_b[p]});
            chk("pass_order", $sformatf("p%0d_s", p), {qu_sa, qu_sb}, {po_sa[p], po_sb[p]});
            chk("pass_order", $sformatf("p%0d_cfg", p), qu_cfg, 4'b1011);
            @(posedge clk); e++; @(negedge clk);
        end
        chk("pass_order", "idle_drive", {qu_a, qu_b, qu_sa, qu_sb, qu_cfg}, 0);
        got = 1'b0;
        while (!got && e < 20) begin
            if (out_valid) got = 1'b1;
            else begin @(posedge clk); e++; @(negedge clk); end
        end
        chk("pass_order", "done", got, 1);
        chk("pass_order", "latency", e, 6);
        chk("pass_order", "out_data", out_data, 16'hEA20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of ISSUE, after one pass has been accumulated.
        start_op("mid_reset", 2'b01, 0, 1, 8'hC8, 8'h64);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("mid_reset", "issuing", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(mk("post_reset", 2'b00, 0, 1, 8'h03, 8'h04, 4'h3, 4'h4, 4'hB, 2'b00, 2'b00, 3, 0, 16'd12));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
